// File: rtl/boot_loader_if.sv
// Byte-stream input and memory write port of the boot loader, grouped for the CPU top level.
// The slave side is the loader; the master side is the byte source / memory observer.
interface boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/boot_loader.sv
// Loads a little-endian program image (32-bit word count header, then words) into memory,
// holding the CPU in reset until the final word has been written.
module boot_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    boot_loader_if.slave     bus,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_error,
    output logic [31:0]      words_loaded
);

    localparam logic [1:0] HDR  = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic [31:0] word_count;
    logic        accept;
    logic        last_byte;
    logic [31:0] full_word;

    assign bus.rx_ready = (state == HDR) || (state == LOAD);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign last_byte    = accept && (byte_cnt == 2'd3);
    assign full_word    = {bus.rx_data, partial};
    assign load_error   = (state == ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HDR;
            byte_cnt     <= 2'd0;
            partial      <= 24'd0;
            word_count   <= 32'd0;
            words_loaded <= 32'd0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= BASE_ADDR;
            bus.mem_data <= 32'd0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            // Release trails the RUN entry by one edge so the write has fully settled.
            cpu_reset  <= (state != RUN);
            load_done  <= (state == RUN);

            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    partial[7:0]   <= bus.rx_data;
                    2'd1:    partial[15:8]  <= bus.rx_data;
                    2'd2:    partial[23:16] <= bus.rx_data;
                    default: ;
                endcase
            end

            case (state)
                HDR: begin
                    if (last_byte) begin
                        word_count <= full_word;
                        if (full_word == 32'd0)
                            state <= RUN;
                        else if (full_word > 32'(MAX_WORDS))
                            state <= ERR;
                        else
                            state <= LOAD;
                    end
                end
                LOAD: begin
                    // Finishing takes priority: any byte arriving with the final strobe is surplus.
                    if (bus.mem_we && (words_loaded == word_count)) begin
                        state <= RUN;
                    end else if (last_byte) begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= BASE_ADDR + {words_loaded[29:0], 2'b00};
                        bus.mem_data <= full_word;
                        words_loaded <= words_loaded + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: stimulus pushes expected memory writes, a monitor pops them.
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h0;
    localparam int unsigned MAXW = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_reset, load_done, load_error;
    logic [31:0] words_loaded;

    boot_loader_if bus ();

    boot_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one byte and return just after the edge on which it is offered.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'((w >> (8 * i)) & 32'hFF));
            if (max_gap > 0)
                idle($urandom_range(0, max_gap));
        end
    endtask

    // Reference: word k of the image must land at BASE + 4k.
    task automatic sendImage(input logic [31:0] words [$], input int max_gap);
        for (int k = 0; k < words.size(); k++) begin
            exp_q.push_back({BASE + 32'(4 * k), words[k]});
            sendWord(words[k], max_gap);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
        checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        checkOutput({tag, "_words_loaded"}, words_loaded, 32'd0);
        checkOutput({tag, "_load_done"}, 32'(load_done), 32'd0);
        checkOutput({tag, "_load_error"}, 32'(load_error), 32'd0);
        checkOutput({tag, "_mem_addr"}, bus.mem_addr, BASE);
        checkOutput({tag, "_mem_data"}, bus.mem_data, 32'd0);
    endtask

    // Release timing relative to the edge accepting the final byte.
    task automatic checkRelease(input string tag, input logic [31:0] nwords);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput({tag, "_cpu_reset_t1"}, 32'(cpu_reset), 32'd1);
        checkOutput({tag, "_mem_we_t1"}, 32'(bus.mem_we), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_cpu_reset_t2"}, 32'(cpu_reset), 32'd1);
        checkOutput({tag, "_mem_we_t2"}, 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_cpu_reset_t3"}, 32'(cpu_reset), 32'd0);
        checkOutput({tag, "_load_done"}, 32'(load_done), 32'd1);
        checkOutput({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        checkOutput({tag, "_words_loaded"}, words_loaded, nwords);
        checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got write 0x%08h @0x%08h, expected none",
                         bus.mem_data, bus.mem_addr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                checkOutput("write_addr", bus.mem_addr, e[63:32]);
                checkOutput("write_data", bus.mem_data, e[31:0]);
            end
        end
    end

    initial begin
        logic [31:0] img [$];

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        doReset();
        checkResetState("reset");

        $display("[TB] two-word directed image");
        sendWord(32'd2, 0);
        img = '{32'h20220013, 32'h12345678};
        sendImage(img, 0);
        checkRelease("two_word", 32'd2);

        $display("[TB] empty image");
        doReset();
        sendWord(32'd0, 0);
        idle(3);
        checkOutput("empty_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("empty_load_done", 32'(load_done), 32'd1);
        checkOutput("empty_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("empty_words_loaded", words_loaded, 32'd0);

        $display("[TB] oversize header");
        doReset();
        sendWord(MAXW + 1, 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput("err_load_error", 32'(load_error), 32'd1);
        checkOutput("err_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("err_cpu_reset", 32'(cpu_reset), 32'd1);
        for (int i = 0; i < 8; i++)
            applyStimulus(8'($urandom));
        idle(3);
        checkOutput("err_still_error", 32'(load_error), 32'd1);
        checkOutput("err_cpu_reset_late", 32'(cpu_reset), 32'd1);
        checkOutput("err_words_loaded", words_loaded, 32'd0);

        $display("[TB] header at the size limit");
        doReset();
        sendWord(MAXW, 0);
        idle(2);
        checkOutput("max_load_error", 32'(load_error), 32'd0);
        checkOutput("max_rx_ready", 32'(bus.rx_ready), 32'd1);
        checkOutput("max_cpu_reset", 32'(cpu_reset), 32'd1);

        $display("[TB] random three-word image with gaps");
        doReset();
        sendWord(32'd3, 5);
        img = '{$urandom, $urandom, $urandom};
        sendImage(img, 5);
        idle(6);
        checkOutput("gap_load_done", 32'(load_done), 32'd1);
        checkOutput("gap_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("gap_words_loaded", words_loaded, 32'd3);
        for (int i = 0; i < 8; i++)
            applyStimulus(8'($urandom));
        idle(3);
        checkOutput("gap_extra_words_loaded", words_loaded, 32'd3);
        checkOutput("gap_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset in the middle of a load");
        doReset();
        sendWord(32'd3, 0);
        img = '{$urandom, $urandom};
        sendImage(img, 2);
        idle(3);
        checkOutput("mid_words_loaded", words_loaded, 32'd2);
        checkOutput("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        doReset();
        checkResetState("mid_reset");
        sendWord(32'd1, 0);
        img = '{$urandom};
        sendImage(img, 0);
        checkRelease("reload", 32'd1);

        idle(2);
        checkOutput("final_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
